// File: rtl/sad_accum_min.sv
// Block-matching SAD accumulator: sums BEATS beats of four absolute differences per candidate
// and tracks the minimum-SAD candidate. Optional early termination: define SAD_EARLY_TERM_EN.
module sad_accum_min #(
  parameter int BEATS  = 64,
  parameter int SAD_W  = 16,
  parameter int CAND_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SAD_W-1:0]  best_sad,
  output logic [CAND_W-1:0] best_idx
`ifdef SAD_EARLY_TERM_EN
  ,
  output logic [CAND_W-1:0] term_cnt
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int EXT_W = SAD_W + 11;

  typedef enum logic [1:0] {ACCUM, COMPARE, DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [SAD_W-1:0]    r_cand_sum;
  logic [SAD_W-1:0]    r_best_sad;
  logic [CAND_W-1:0]   r_cand_idx;
  logic [CAND_W-1:0]   r_best_idx;
  logic                r_first;
  logic                r_last;
  logic                r_out_valid;

  logic                w_xfer;
  logic                w_final_beat;
  logic                w_better;
  logic                w_accum_en;
  logic [9:0]          w_byte_ext [4];
  logic [9:0]          w_beat_sum;
  logic [EXT_W-1:0]    w_sum_ext;
  logic [SAD_W-1:0]    w_sum_sat;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign w_byte_ext[gi] = {2'b00, in_data[8*gi +: 8]};
    end
  endgenerate

  // Four bytes peak at 1020, so a 10-bit beat sum never wraps.
  assign w_beat_sum = w_byte_ext[0] + w_byte_ext[1] + w_byte_ext[2] + w_byte_ext[3];
  assign w_sum_ext  = EXT_W'(r_cand_sum) + EXT_W'(w_beat_sum);
  assign w_sum_sat  = (|w_sum_ext[EXT_W-1:SAD_W]) ? '1 : w_sum_ext[SAD_W-1:0];

  assign w_xfer       = in_valid && in_ready;
  assign w_final_beat = w_xfer && (r_beat_cnt == CNT_W'(BEATS - 1));

`ifdef SAD_EARLY_TERM_EN
  logic              r_frozen;
  logic [CAND_W-1:0] r_term_cnt;
  assign w_accum_en = !r_frozen;
  assign w_better   = r_first || (!r_frozen && (r_cand_sum < r_best_sad));
  assign term_cnt   = r_term_cnt;

  // A candidate whose running sum already reaches the best can never win; stop adding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frozen   <= 1'b0;
      r_term_cnt <= '0;
    end else begin
      if (w_xfer && !r_frozen && !r_first && (w_sum_sat >= r_best_sad))
        r_frozen <= 1'b1;
      if (r_state == COMPARE) begin
        r_frozen <= 1'b0;
        if (r_frozen)
          r_term_cnt <= r_term_cnt + CAND_W'(1);
      end
      if (r_state == DONE && out_ready)
        r_term_cnt <= '0;
    end
  end
`else
  assign w_accum_en = 1'b1;
  assign w_better   = r_first || (r_cand_sum < r_best_sad);
`endif

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (w_final_beat)
          w_state_next = COMPARE;
      end
      COMPARE: w_state_next = r_last ? DONE : ACCUM;
      DONE:    if (out_ready) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_beat_cnt  <= '0;
      r_cand_sum  <= '0;
      r_cand_idx  <= '0;
      r_best_sad  <= '0;
      r_best_idx  <= '0;
      r_first     <= 1'b1;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        if (w_final_beat) begin
          r_beat_cnt <= '0;
          r_last     <= in_last;
        end else begin
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
        if (w_accum_en)
          r_cand_sum <= w_sum_sat;
      end
      // Strict less-than keeps the earliest index on ties.
      if (r_state == COMPARE) begin
        if (w_better) begin
          r_best_sad <= r_cand_sum;
          r_best_idx <= r_cand_idx;
        end
        r_first    <= 1'b0;
        r_cand_sum <= '0;
        r_cand_idx <= r_cand_idx + CAND_W'(1);
        if (r_last)
          r_out_valid <= 1'b1;
      end
      if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
        r_cand_idx  <= '0;
        r_first     <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign best_sad  = r_best_sad;
  assign best_idx  = r_best_idx;

endmodule
